bram_axis_reader: RTL and testbench
===================================

BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

Interface
REQ-001: Parameter DATA_WIDTH, default 64, sets the RAM word width and the m_axis_tdata width.
REQ-002: Parameter DEPTH, default 512, sets the RAM entries; ADDR_WIDTH = ceil(log2(DEPTH)).
REQ-003: clk  in  1  single clock; all logic SHALL be rising-edge clk.
REQ-004: rst_n  in  1  asynchronous, active-low reset.
REQ-005: cmd_valid  in  1  a read command is presented.
REQ-006: cmd_ready  out  1  the command is accepted this cycle.
REQ-007: cmd_addr  in  ADDR_WIDTH  start word address.
REQ-008: cmd_len  in  ADDR_WIDTH+1  word count; 0 is legal (empty command).
REQ-009: ram_addrb  out  ADDR_WIDTH  read address to the SDP RAM.
REQ-010: ram_enb  out  1  read issue strobe.
REQ-011: ram_regceb  out  1  RAM output register enable, SHALL be constant 1.
REQ-012: ram_rstb  out  1  RAM output reset, SHALL be constant 0.
REQ-013: ram_doutb  in  DATA_WIDTH  RAM read data; valid 2 cycles after the ram_enb cycle.
REQ-014: m_axis_tdata  out  DATA_WIDTH  stream data.
REQ-015: m_axis_tvalid  out  1  stream valid.
REQ-016: m_axis_tready  in  1  stream ready.
REQ-017: m_axis_tlast  out  1  marks the final word of a command.
REQ-018: busy  out  1  high whenever the state is not IDLE.

Function
REQ-019: FSM states SHALL be IDLE, ISSUE and DRAIN; cmd_ready = (state==IDLE).
REQ-020: IDLE -> ISSUE on cmd_valid&&cmd_ready when cmd_len>0; the block SHALL latch addr and len.
REQ-021: On cmd_len==0 the handshake SHALL complete, no reads SHALL be issued, no beats SHALL be emitted, and the state SHALL stay IDLE.
REQ-022: In ISSUE, ram_enb SHALL pulse for one word per cycle while credit > 0; ram_addrb SHALL increment by 1 per issue and wrap from DEPTH-1 to 0.
REQ-023: Credit SHALL be 4 - (buffer occupancy + words in flight); no issue SHALL occur at credit 0, so the buffer never overflows.
REQ-024: An in-flight tracker (2-stage valid+last shift register) SHALL write ram_doutb into a 4-entry output FIFO exactly 2 cycles after its issue.
REQ-025: m_axis_tvalid SHALL rise the cycle after the word enters the FIFO; first issue is at cycle C+1 after command accept at edge C, and the first tvalid is at cycle C+4.
REQ-026: When m_axis_tready is held high, the block SHALL sustain 1 beat/cycle with no bubbles after the first beat.
REQ-027: A beat transfers on tvalid&&tready; while tvalid&&!tready, tdata and tlast SHALL hold stable.
REQ-028: tlast SHALL be 1 only on word len-1 of the command.
REQ-029: ISSUE -> DRAIN once len words are issued; DRAIN -> IDLE on the tlast transfer.
REQ-030: A FIFO write and a FIFO read in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-031: cmd_len==DEPTH SHALL read every entry once, starting at cmd_addr and wrapping.

Reset
REQ-032: On rst_n low the block SHALL asynchronously clear the state to IDLE and the FIFO, tracker and credit.
REQ-033: Output reset values: tvalid=0, tlast=0, tdata=0, ram_enb=0, ram_addrb=0, busy=0, cmd_ready=0 while rst_n is low, and cmd_ready=1 from the first edge after release.
REQ-034: Reset mid-transfer SHALL drop in-flight data; the next command SHALL start clean.

Verification
REQ-035: RAM[i]=i, cmd addr=5 len=3, tready=1 -> beats 5,6,7 on cycles C+4..C+6; tlast on 7; busy low after.
REQ-036: addr=DEPTH-2, len=4 -> beats DEPTH-2, DEPTH-1, 0, 1; tlast on 1.
REQ-037: len=16 with tready low 10 cycles, then high -> at most 4 issues during the stall; all 16 words in order, none lost or duplicated.
REQ-038: Random tready toggling, len=DEPTH -> all DEPTH words emitted in order; tdata stable while stalled.
REQ-039: len=0 -> cmd accepted in 1 cycle; no ram_enb, no tvalid; cmd_ready stays 1.
REQ-040: rst_n pulsed low mid-transfer (word 3 of 8) -> tvalid=0 immediately; a new cmd addr=0 len=2 -> beats 0,1 only.

Source files
------------

// File: rtl/bram_axis_reader.sv
// bram_axis_reader: streams a run of words out of a simple dual-port RAM
// (two-cycle read latency) onto an AXI-Stream master. Reads are issued
// against a credit window so the four-entry output buffer can never
// overflow, while back-to-back beats are sustained when the sink is ready.
module bram_axis_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    // RAM read port
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    // stream out
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            FIFO_SLOTS = 3'd4;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic [ADDR_WIDTH-1:0] r_ram_addrb;
    logic                  r_ram_enb;
    logic                  r_enb_last;

    // in-flight tracker: valid+last for the two RAM pipeline stages
    logic                  r_trk1_v;
    logic                  r_trk1_l;
    logic                  r_trk2_v;
    logic                  r_trk2_l;

    logic [DATA_WIDTH-1:0] r_fifo_data [4];
    logic [3:0]            r_fifo_last;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    logic                  w_cmd_fire;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_inflight;
    logic [2:0]            w_level;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    assign w_tvalid   = (r_count != 3'd0);
    assign w_tlast    = w_tvalid & r_fifo_last[r_rd_ptr];
    assign w_pop      = w_tvalid & m_axis_tready;
    assign w_push     = r_trk2_v;

    // Occupancy is taken net of the beat leaving this cycle so a full
    // pipeline with a ready sink still has one credit every cycle.
    assign w_inflight   = 3'(r_ram_enb) + 3'(r_trk1_v) + 3'(r_trk2_v);
    assign w_level      = r_count + w_inflight - 3'(w_pop);
    assign w_credit_ok  = (w_level < FIFO_SLOTS);
    assign w_issue      = (r_state == ISSUE) && w_credit_ok;
    assign w_issue_last = (r_remain == (ADDR_WIDTH + 1)'(1));
    assign w_addr_inc   = (r_next_addr == LAST_ADDR) ? '0 : r_next_addr + ADDR_WIDTH'(1);

    // Command FSM: accepts commands, issues RAM reads, waits for the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_next_addr <= '0;
            r_remain    <= '0;
            r_ram_addrb <= '0;
            r_ram_enb   <= 1'b0;
            r_enb_last  <= 1'b0;
        end else begin
            r_ram_enb  <= 1'b0;
            r_enb_last <= 1'b0;
            case (r_state)
                IDLE: begin
                    // zero-length commands complete the handshake and stay here
                    if (w_cmd_fire && (cmd_len != '0)) begin
                        r_state     <= ISSUE;
                        r_cmd_ready <= 1'b0;
                        r_next_addr <= cmd_addr;
                        r_remain    <= cmd_len;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_ram_enb   <= 1'b1;
                        r_ram_addrb <= r_next_addr;
                        r_enb_last  <= w_issue_last;
                        r_next_addr <= w_addr_inc;
                        r_remain    <= r_remain - (ADDR_WIDTH + 1)'(1);
                        if (w_issue_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_tlast) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Tracker: follows each issued read through the RAM's two-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk1_v <= 1'b0;
            r_trk1_l <= 1'b0;
            r_trk2_v <= 1'b0;
            r_trk2_l <= 1'b0;
        end else begin
            r_trk1_v <= r_ram_enb;
            r_trk1_l <= r_enb_last;
            r_trk2_v <= r_trk1_v;
            r_trk2_l <= r_trk1_l;
        end
    end

    // Output FIFO: captures RAM data when the tracker matures, pops on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_doutb;
                r_fifo_last[r_wr_ptr] <= r_trk2_l;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = (r_state != IDLE);
    assign ram_addrb     = r_ram_addrb;
    assign ram_enb       = r_ram_enb;
    assign ram_regceb    = 1'b1;
    assign ram_rstb      = 1'b0;
    assign m_axis_tdata  = r_fifo_data[r_rd_ptr];
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tlast  = w_tlast;

endmodule

// File: tb/tb_bram_axis_reader.sv
// Bench for bram_axis_reader: behavioural RAM (RAM[i] = i, two-cycle read),
// scoreboard of expected beats filled at command accept and drained by a
// monitor on the falling edge.
module tb_bram_axis_reader;

    localparam int DW    = 64;
    localparam int DEPTH = 512;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] ram_addrb;
    logic          ram_enb;
    logic          ram_regceb;
    logic          ram_rstb;
    logic [DW-1:0] ram_doutb = '0;
    logic [DW-1:0] ram_lat = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          busy;

    bram_axis_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .ram_addrb     (ram_addrb),
        .ram_enb       (ram_enb),
        .ram_regceb    (ram_regceb),
        .ram_rstb      (ram_rstb),
        .ram_doutb     (ram_doutb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SDP RAM with output register: contents RAM[i] = i
    always @(posedge clk) begin
        if (ram_enb) ram_lat <= DW'(ram_addrb);
        ram_doutb <= ram_lat;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            due;
    } beat_t;

    beat_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int issued  = 0;
    int popped  = 0;
    int beats   = 0;
    int first_enb_cyc = -1;
    int accept_c = 0;
    int last_wait = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_ok(input string name, input bit ok, input int act, input int lim);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, limit %0d", name, act, lim);
    endtask

    // Monitor: scoreboard pop, hold-while-stalled and credit-window checks.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            issued = 0;
            popped = 0;
        end else begin
            check_eq("busy_vs_ready", 64'(busy), 64'(!cmd_ready));
            if (prev_stall) begin
                check_eq("hold_tvalid", 64'(m_axis_tvalid), 64'(1));
                check_eq("hold_tdata", m_axis_tdata, prev_data);
                check_eq("hold_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (ram_enb) begin
                issued++;
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                popped++;
                beats++;
                if (exp_q.size() == 0) begin
                    check_ok("unexpected_beat", 1'b0, int'(m_axis_tdata), -1);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_eq("tdata", m_axis_tdata, b.data);
                    check_eq("tlast", 64'(m_axis_tlast), 64'(b.last));
                    if (b.due >= 0) check_eq("beat_cycle", 64'(cyc), 64'(b.due));
                end
            end
            if (ram_enb) check_ok("credit_window", (issued - popped) <= 4, issued - popped, 4);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    // Present one command; expected beats go to the scoreboard at accept.
    task automatic send_cmd(input int addr, input int len, input bit timed);
        int budget;
        budget = 200;
        last_wait = 0;
        first_enb_cyc = -1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW + 1)'(len);
        @(negedge clk);
        while (!cmd_ready && budget > 0) begin
            @(negedge clk);
            budget--;
            last_wait++;
        end
        if (!cmd_ready) begin
            check_ok("cmd_accept_timeout", 1'b0, last_wait, 200);
        end else begin
            accept_c = cyc + 1;
            for (int i = 0; i < len; i++) begin
                beat_t b;
                b.data = DW'((addr + i) % DEPTH);
                b.last = (i == len - 1);
                b.due  = timed ? accept_c + 4 + i : -1;
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= budget) check_ok("idle_timeout", 1'b0, exp_q.size(), 0);
        m_axis_tready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int snap_i;
        int snap_b;
        int n;

        // reset values
        #2;
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check_eq("rst_tdata", m_axis_tdata, 64'(0));
        check_eq("rst_enb", 64'(ram_enb), 64'(0));
        check_eq("rst_addrb", 64'(ram_addrb), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("regceb", 64'(ram_regceb), 64'(1));
        check_eq("rstb", 64'(ram_rstb), 64'(0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        check_eq("ready_after_release", 64'(cmd_ready), 64'(1));

        // basic read: beats 5,6,7 on C+4..C+6
        send_cmd(5, 3, 1'b1);
        while (cyc < accept_c + 7) @(negedge clk);
        check_eq("first_issue_cycle", 64'(first_enb_cyc), 64'(accept_c + 1));
        check_eq("busy_after_tlast", 64'(busy), 64'(0));
        check_eq("tvalid_after_tlast", 64'(m_axis_tvalid), 64'(0));
        check_eq("queue_drained", 64'(exp_q.size()), 64'(0));

        // address wrap
        send_cmd(DEPTH - 2, 4, 1'b1);
        wait_idle(1'b0, 100);

        // sink stalled for 10 cycles
        m_axis_tready = 1'b0;
        snap_i = issued;
        send_cmd(100, 16, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_ok("stall_issue_count", (issued - snap_i) <= 4 && (issued - snap_i) > 0,
                 issued - snap_i, 4);
        m_axis_tready = 1'b1;
        wait_idle(1'b0, 200);

        // full-depth read with random backpressure
        send_cmd(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b0);
        wait_idle(1'b1, 5000);

        // zero-length command
        snap_i = issued;
        snap_b = beats;
        send_cmd(7, 0, 1'b0);
        check_eq("len0_accept_wait", 64'(last_wait), 64'(0));
        repeat (6) begin
            @(negedge clk);
            check_eq("len0_ready", 64'(cmd_ready), 64'(1));
            check_eq("len0_tvalid", 64'(m_axis_tvalid), 64'(0));
        end
        check_eq("len0_no_issue", 64'(issued - snap_i), 64'(0));
        check_eq("len0_no_beats", 64'(beats - snap_b), 64'(0));

        // random short commands with random backpressure
        for (int k = 0; k < 8; k++) begin
            send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)), 1'b0);
            wait_idle(1'b1, 600);
        end

        // reset in the middle of an 8-word transfer
        m_axis_tready = 1'b1;
        snap_b = beats;
        send_cmd(40, 8, 1'b0);
        n = 0;
        while (beats - snap_b < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_ok("mid_reset_reached", (beats - snap_b) >= 3, beats - snap_b, 3);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("mid_rst_enb", 64'(ram_enb), 64'(0));
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        check_eq("mid_rst_ready", 64'(cmd_ready), 64'(0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_mid_rst", 64'(cmd_ready), 64'(1));
        snap_b = beats;
        send_cmd(0, 2, 1'b1);
        wait_idle(1'b0, 100);
        repeat (8) @(negedge clk);
        check_eq("post_reset_beats", 64'(beats - snap_b), 64'(2));
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
